// File: rtl/eth_smi_responder.sv
// eth_smi_responder: clause-22 MDIO/SMI PHY-side responder serving a 32x16 register file.
// MDC/MDIO are sampled in the clk_mac domain; mdio_o/mdio_oe feed an external tristate buffer.
module eth_smi_responder #(
    parameter logic [4:0]  PHY_ADDR  = 5'd1,
    parameter logic [15:0] PHYID1    = 16'h0007,
    parameter logic [15:0] PHYID2    = 16'hC0F1,
    parameter logic [15:0] BMCR_INIT = 16'h3100,
    parameter logic [15:0] ANAR_INIT = 16'h01E1
) (
    input  logic        clk_mac,
    input  logic        rst,
    input  logic        eth_mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic [15:0] status_bmsr,
    output logic        busy,
    output logic        wr_strobe,
    output logic [4:0]  wr_reg,
    output logic [15:0] wr_data
);
    typedef enum logic [3:0] {HUNT, ST2, OP, ADDR, SKIP, TA, RD, WR, WDONE} state_t;
    state_t state_q, state_d;
    logic [2:0]  mdc_q;
    logic [1:0]  mdi_q;
    logic [5:0]  cnt_q, cnt_d;
    logic [9:0]  addr_q, addr_d;
    logic [15:0] sr_q, sr_d;
    logic        rd_q, rd_d, b1_q, b1_d;
    logic        oe_q, oe_d, o_q, o_d, busy_q, busy_d, stb_q, stb_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [15:0] wdat_q, wdat_d;
    logic [15:0] regs_q [32];
    logic [15:0] regs_d [32];
    logic        rise, b;
    logic [4:0]  ra;
    logic [15:0] rdv;
    function automatic logic [15:0] rst_val(input logic [4:0] a);
        return a == 5'd0 ? BMCR_INIT : a == 5'd4 ? ANAR_INIT : 16'h0;
    endfunction
    assign rise = mdc_q[1] & ~mdc_q[2];
    assign b    = mdi_q[1];
    assign ra   = {addr_q[3:0], b};
    assign rdv  = ra == 5'd1 ? status_bmsr : ra == 5'd2 ? PHYID1 : ra == 5'd3 ? PHYID2 : regs_q[ra];
    always_ff @(posedge clk_mac or posedge rst) begin
        if (rst) begin
            mdc_q   <= '0;
            mdi_q   <= '0;
            state_q <= HUNT;
            cnt_q   <= '0;
            addr_q  <= '0;
            sr_q    <= '0;
            rd_q    <= 1'b0;
            b1_q    <= 1'b0;
            oe_q    <= 1'b0;
            o_q     <= 1'b0;
            busy_q  <= 1'b0;
            stb_q   <= 1'b0;
            wreg_q  <= '0;
            wdat_q  <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= rst_val(5'(i));
        end else begin
            mdc_q   <= {mdc_q[1:0], eth_mdc};
            mdi_q   <= {mdi_q[0], mdio_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            sr_q    <= sr_d;
            rd_q    <= rd_d;
            b1_q    <= b1_d;
            oe_q    <= oe_d;
            o_q     <= o_d;
            busy_q  <= busy_d;
            stb_q   <= stb_d;
            wreg_q  <= wreg_d;
            wdat_q  <= wdat_d;
            regs_q  <= regs_d;
        end
    end
    // cnt doubles as preamble counter in HUNT and as bit index in every other field
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == WDONE) begin
            state_d = HUNT;
            cnt_d   = '0;
        end else if (rise) begin
            case (state_q)
                HUNT: begin
                    cnt_d   = b ? (cnt_q == 6'd32 ? 6'd32 : cnt_q + 6'd1) : 6'd0;
                    state_d = (!b && cnt_q == 6'd32) ? ST2 : HUNT;
                end
                ST2:  state_d = b ? OP : HUNT;
                OP: begin
                    cnt_d   = cnt_q == 6'd0 ? 6'd1 : 6'd0;
                    state_d = cnt_q == 6'd0 ? OP : (b1_q ^ b) ? ADDR : HUNT;
                end
                ADDR: begin
                    cnt_d   = cnt_q == 6'd9 ? 6'd0 : cnt_q + 6'd1;
                    state_d = cnt_q != 6'd9 ? ADDR : addr_q[8:4] == PHY_ADDR ? TA : SKIP;
                end
                SKIP: begin
                    cnt_d   = cnt_q == 6'd17 ? 6'd0 : cnt_q + 6'd1;
                    state_d = cnt_q == 6'd17 ? HUNT : SKIP;
                end
                TA: begin
                    cnt_d   = cnt_q == 6'd0 ? 6'd1 : 6'd0;
                    state_d = cnt_q == 6'd0 ? TA : rd_q ? RD : {b1_q, b} == 2'b10 ? WR : HUNT;
                end
                RD: begin
                    cnt_d   = cnt_q == 6'd16 ? 6'd0 : cnt_q + 6'd1;
                    state_d = cnt_q == 6'd16 ? HUNT : RD;
                end
                WR: begin
                    cnt_d   = cnt_q == 6'd15 ? 6'd0 : cnt_q + 6'd1;
                    state_d = cnt_q == 6'd15 ? WDONE : WR;
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = '0;
                end
            endcase
        end
    end
    always_comb begin
        b1_d   = rise ? b : b1_q;
        addr_d = (rise && state_q == ADDR) ? {addr_q[8:0], b} : addr_q;
        rd_d   = (rise && state_q == OP && cnt_q == 6'd1) ? b1_q : rd_q;
        busy_d = state_d != HUNT;
        sr_d   = sr_q;
        oe_d   = oe_q;
        o_d    = o_q;
        stb_d  = 1'b0;
        wreg_d = wreg_q;
        wdat_d = wdat_q;
        regs_d = regs_q;
        if (rise && state_q == ADDR && cnt_q == 6'd9) sr_d = rdv;
        if (rise && state_q == WR) sr_d = {sr_q[14:0], b};
        if (rise && state_q == TA && cnt_q == 6'd1 && rd_q) begin
            oe_d = 1'b1;
            o_d  = 1'b0;
        end
        if (rise && state_q == RD) begin
            oe_d = cnt_q != 6'd16;
            o_d  = cnt_q != 6'd16 && sr_q[15];
            sr_d = {sr_q[14:0], 1'b0};
        end
        if (state_q == WDONE) begin
            stb_d  = 1'b1;
            wreg_d = addr_q[4:0];
            wdat_d = sr_q;
            if (addr_q[4:0] == 5'd0 && sr_q[15])
                for (int i = 0; i < 32; i++) regs_d[i] = rst_val(5'(i));
            else if (addr_q[4:0] == 5'd0 || addr_q[4:0] > 5'd3)
                regs_d[addr_q[4:0]] = sr_q;
        end
    end
    always_comb begin
        mdio_o    = o_q;
        mdio_oe   = oe_q;
        busy      = busy_q;
        wr_strobe = stb_q;
        wr_reg    = wreg_q;
        wr_data   = wdat_q;
    end
endmodule

// File: tb/tb_eth_smi_responder.sv
// tb_eth_smi_responder: SMI master driving frames against a frame-level register model.
// Drive expectations are checked every low MDC phase; literal read-backs pin the model.
module tb_eth_smi_responder;
    localparam logic [4:0] PHY = 5'd1;
    logic clk = 0, rst = 1, mdc = 0, m_drv = 1, m_rel = 1;
    logic mdio_line, mdio_o, mdio_oe, busy, wr_strobe;
    logic [15:0] status_bmsr = 16'h7809, wr_data;
    logic [4:0] wr_reg;
    int checks = 0, failures = 0, nstb = 0;
    logic chk = 0, exp_oe = 0, exp_o = 0;
    logic [4:0] last_reg = 0;
    logic [15:0] last_data = 0, got;
    logic [15:0] mregs [32];

    eth_smi_responder dut (
        .clk_mac(clk), .rst(rst), .eth_mdc(mdc), .mdio_i(mdio_line),
        .mdio_o(mdio_o), .mdio_oe(mdio_oe), .status_bmsr(status_bmsr),
        .busy(busy), .wr_strobe(wr_strobe), .wr_reg(wr_reg), .wr_data(wr_data)
    );

    assign mdio_line = mdio_oe ? mdio_o : (m_rel ? 1'b1 : m_drv);
    always #5 clk = ~clk;
    always @(posedge clk) if (wr_strobe) nstb++;

    task automatic chk1(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) if (chk) begin
        chk1("mdio_oe", 32'(mdio_oe), 32'(exp_oe));
        if (exp_oe) chk1("mdio_o", 32'(mdio_o), 32'(exp_o));
        chk1("wr_reg", 32'(wr_reg), 32'(last_reg));
        chk1("wr_data", 32'(wr_data), 32'(last_data));
    end

    task automatic mreset();
        for (int i = 0; i < 32; i++) mregs[i] = 16'h0;
        mregs[0] = 16'h3100;
        mregs[4] = 16'h01E1;
    endtask

    function automatic logic [15:0] mread(input logic [4:0] r);
        if (r == 1) return status_bmsr;
        if (r == 2) return 16'h0007;
        if (r == 3) return 16'hC0F1;
        return mregs[r];
    endfunction

    task automatic mwrite(input logic [4:0] r, input logic [15:0] d);
        if (r == 0 && d[15]) mreset();
        else if (r == 0 || r > 3) mregs[r] = d;
    endtask

    // one MDC period: low phase (checked), then high phase; n_oe/n_o is what the rise must produce
    task automatic bit_cyc(input logic bv, input logic rel, input logic n_oe, input logic n_o, output logic smp);
        m_drv = bv;
        m_rel = rel;
        chk = 1;
        repeat (5) @(posedge clk);
        chk = 0;
        @(posedge clk);
        #1 mdc = 1;
        repeat (6) @(posedge clk);
        #1 smp = mdio_line;
        mdc = 0;
        exp_oe = n_oe;
        exp_o = n_o;
    endtask

    task automatic frame(input int pre, input logic [1:0] st, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] rg, input logic [1:0] ta, input logic [15:0] d,
                         input int rst_at, output logic [15:0] rdata);
        logic rd, wr, oks, ok, s;
        logic [15:0] rv;
        int ns;
        rd = op == 2'b10;
        wr = op == 2'b01;
        oks = pre >= 32 && st == 2'b01;
        ok = oks && (rd || wr) && phy == PHY && (rd || ta == 2'b10);
        rv = mread(rg);
        rdata = 16'h0;
        ns = nstb;
        bit_cyc(0, 0, 0, 0, s);
        repeat (pre) bit_cyc(1, 0, 0, 0, s);
        for (int i = 1; i >= 0; i--) bit_cyc(st[i], 0, 0, 0, s);
        for (int i = 1; i >= 0; i--) bit_cyc(op[i], 0, 0, 0, s);
        for (int i = 4; i >= 0; i--) bit_cyc(phy[i], 0, 0, 0, s);
        for (int i = 4; i >= 0; i--) bit_cyc(rg[i], 0, 0, 0, s);
        if (oks && (rd || wr)) chk1("busy_mid", 32'(busy), 1);
        if (rd && ok) begin
            bit_cyc(1, 1, 0, 0, s);
            bit_cyc(1, 1, 1, 0, s);
            for (int k = 0; k < 16; k++) begin
                bit_cyc(1, 1, 1, rv[15-k], s);
                rdata[15-k] = s;
                if (k == rst_at) begin
                    repeat (2) @(posedge clk);
                    #2 rst = 1;
                    #1 chk1("rst_oe", 32'(mdio_oe), 0);
                    chk1("rst_busy", 32'(busy), 0);
                    chk1("rst_o", 32'(mdio_o), 0);
                    repeat (3) @(negedge clk);
                    rst = 0;
                    mreset();
                    last_reg = 0;
                    last_data = 0;
                    exp_oe = 0;
                    exp_o = 0;
                    return;
                end
            end
        end else if (rd) begin
            repeat (18) bit_cyc(1, 1, 0, 0, s);
        end else begin
            for (int i = 1; i >= 0; i--) bit_cyc(ta[i], 0, 0, 0, s);
            for (int i = 15; i >= 0; i--) bit_cyc(d[i], 0, 0, 0, s);
        end
        if (wr && ok) begin
            mwrite(rg, d);
            last_reg = rg;
            last_data = d;
            ns++;
        end
        bit_cyc(1, 1, 0, 0, s);
        chk1("busy_end", 32'(busy), 0);
        chk1("strobes", 32'(nstb), 32'(ns));
    endtask

    initial begin
        mreset();
        repeat (4) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk1("rst_mdio_oe", 32'(mdio_oe), 0);
        chk1("rst_mdio_o", 32'(mdio_o), 0);
        chk1("rst_busy", 32'(busy), 0);
        chk1("rst_wr_strobe", 32'(wr_strobe), 0);
        chk1("rst_wr_reg", 32'(wr_reg), 0);
        chk1("rst_wr_data", 32'(wr_data), 0);
        frame(32, 2'b01, 2'b10, PHY, 5'd2, 2'b00, 16'h0, -1, got);
        chk1("read_id1", 32'(got), 32'h0007);
        frame(32, 2'b01, 2'b01, PHY, 5'd4, 2'b10, 16'hABCD, -1, got);
        chk1("wr_reg_lit", 32'(wr_reg), 4);
        chk1("wr_data_lit", 32'(wr_data), 32'hABCD);
        frame(32, 2'b01, 2'b10, PHY, 5'd4, 2'b00, 16'h0, -1, got);
        chk1("read_r4", 32'(got), 32'hABCD);
        frame(32, 2'b01, 2'b01, PHY, 5'd2, 2'b10, 16'h1234, -1, got);
        frame(32, 2'b01, 2'b10, PHY, 5'd2, 2'b00, 16'h0, -1, got);
        chk1("read_r2_ro", 32'(got), 32'h0007);
        frame(32, 2'b01, 2'b01, PHY, 5'd0, 2'b10, 16'h8000, -1, got);
        frame(32, 2'b01, 2'b10, PHY, 5'd4, 2'b00, 16'h0, -1, got);
        chk1("read_r4_soft", 32'(got), 32'h01E1);
        frame(32, 2'b01, 2'b10, PHY, 5'd0, 2'b00, 16'h0, -1, got);
        chk1("read_r0_soft", 32'(got), 32'h3100);
        frame(32, 2'b01, 2'b10, 5'd2, 5'd0, 2'b00, 16'h0, -1, got);
        frame(32, 2'b01, 2'b01, 5'd2, 5'd5, 2'b10, 16'h7777, -1, got);
        frame(31, 2'b01, 2'b01, PHY, 5'd5, 2'b10, 16'h5555, -1, got);
        frame(32, 2'b01, 2'b10, PHY, 5'd5, 2'b00, 16'h0, -1, got);
        chk1("read_r5_filtered", 32'(got), 32'h0000);
        frame(32, 2'b01, 2'b01, PHY, 5'd5, 2'b10, 16'h1111, -1, got);
        frame(32, 2'b01, 2'b10, PHY, 5'd5, 2'b00, 16'h0, -1, got);
        chk1("read_r5", 32'(got), 32'h1111);
        frame(32, 2'b01, 2'b11, PHY, 5'd6, 2'b10, 16'h2222, -1, got);
        frame(32, 2'b01, 2'b01, PHY, 5'd6, 2'b00, 16'h3333, -1, got);
        frame(32, 2'b01, 2'b10, PHY, 5'd6, 2'b00, 16'h0, -1, got);
        chk1("read_r6_bad", 32'(got), 32'h0000);
        frame(32, 2'b01, 2'b01, PHY, 5'd4, 2'b10, 16'hBEEF, -1, got);
        frame(32, 2'b01, 2'b10, PHY, 5'd4, 2'b00, 16'h0, 8, got);
        frame(32, 2'b01, 2'b10, PHY, 5'd0, 2'b00, 16'h0, -1, got);
        chk1("read_r0_after_rst", 32'(got), 32'h3100);
        status_bmsr = 16'h782D;
        frame(32, 2'b01, 2'b10, PHY, 5'd1, 2'b00, 16'h0, -1, got);
        chk1("read_bmsr", 32'(got), 32'h782D);
        frame(33, 2'b01, 2'b10, PHY, 5'd4, 2'b00, 16'h0, -1, got);
        chk1("read_r4_after_rst", 32'(got), 32'h01E1);
        for (int n = 0; n < 24; n++) begin
            int pre, r;
            logic [1:0] st, op, ta;
            logic [4:0] phy, rg;
            logic [15:0] d;
            pre = ($urandom_range(0, 5) == 0) ? 31 : 32 + int'($urandom_range(0, 4));
            st = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01;
            r = int'($urandom_range(0, 9));
            op = r < 4 ? 2'b10 : r < 8 ? 2'b01 : 2'($urandom);
            phy = ($urandom_range(0, 5) == 0) ? 5'($urandom) : PHY;
            rg = 5'($urandom);
            ta = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b10;
            d = 16'($urandom);
            if (rg == 0) d[15] = ($urandom_range(0, 3) == 0);
            status_bmsr = 16'($urandom);
            frame(pre, st, op, phy, rg, ta, d, -1, got);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
